// File: rtl/grid_actor_ctrl.sv
// Tile-stepping controller for maze actors: paced step attempts, buffered turns, map-RAM wall checks.
// Optional horizontal tunnel wrap-around is enabled by defining WRAP_TUNNEL_EN.
//
// state  | meaning
// IDLE   | waiting for a step tick; map address shows current tile
// Q_REQ  | first lookup issued for the neighbour in the pending heading
// Q_WAIT | holding that address until the map result arrives
// Q_EVAL | map result valid; take the pending turn or fall back
// C_REQ  | fallback lookup issued for the neighbour in the current heading
// C_WAIT | holding the fallback address
// C_EVAL | fallback result valid; move straight on or report blocked
module grid_actor_ctrl #(
  parameter int COORD_W     = 5,
  parameter int X_MIN       = 1,
  parameter int X_MAX       = 28,
  parameter int Y_MIN       = 1,
  parameter int Y_MAX       = 28,
  parameter int START_X     = 2,
  parameter int START_Y     = 2,
  parameter int START_DIR   = 3,
  parameter int STEP_DIV    = 15,
  parameter int ANIM_FRAMES = 2,
  parameter int MAP_LAT     = 1,
  localparam int ANIM_W     = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [1:0]         req_dir,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic               map_wall,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic [1:0]         dir,
  output logic [ANIM_W-1:0]  anim,
  output logic               moved,
  output logic               blocked,
  output logic               busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int LAT_W = $clog2(MAP_LAT + 1);

  // One extra bit so that a step off the low edge of the coordinate range is visible.
  typedef logic [COORD_W:0] ext_t;
  localparam ext_t XLO = ext_t'(X_MIN);
  localparam ext_t XHI = ext_t'(X_MAX);
  localparam ext_t YLO = ext_t'(Y_MIN);
  localparam ext_t YHI = ext_t'(Y_MAX);

  typedef enum logic [2:0] {IDLE, Q_REQ, Q_WAIT, Q_EVAL, C_REQ, C_WAIT, C_EVAL} state_t;

  state_t             state;
  logic [DIV_W-1:0]   cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [1:0]         pend;
  logic               tick;
  logic [2*COORD_W:0] nb_req, nb_pend, nb_dir;

  // Returns {in_bounds, target_y, target_x}.
  function automatic logic [2*COORD_W:0] nbr(input logic [1:0] d,
                                             input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y);
    ext_t tx;
    ext_t ty;
    logic inb;
    tx = {1'b0, x};
    ty = {1'b0, y};
    case (d)
      2'd0:    ty = ty - 1'b1;
      2'd1:    tx = tx - 1'b1;
      2'd2:    ty = ty + 1'b1;
      default: tx = tx + 1'b1;
    endcase
`ifdef WRAP_TUNNEL_EN
    if (d == 2'd1 && tx == ext_t'(X_MIN - 1)) tx = XHI;
    if (d == 2'd3 && tx == ext_t'(X_MAX + 1)) tx = XLO;
`else
`endif
    inb = (tx >= XLO) && (tx <= XHI) && (ty >= YLO) && (ty <= YHI);
    return {inb, ty[COORD_W-1:0], tx[COORD_W-1:0]};
  endfunction

  function automatic logic [ANIM_W-1:0] anim_next(input logic [ANIM_W-1:0] a);
    if (ANIM_FRAMES <= 1) return '0;
    return (a == ANIM_W'(ANIM_FRAMES - 1)) ? '0 : a + 1'b1;
  endfunction

  assign tick    = ce && (cnt == DIV_W'(STEP_DIV - 1));
  assign nb_req  = nbr(req_dir, xpos, ypos);
  assign nb_pend = nbr(pend, xpos, ypos);
  assign nb_dir  = nbr(dir, xpos, ypos);

  // busy stays up through the moved/blocked pulse cycle so a step reads as one window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_cnt <= '0;
      pend    <= 2'(START_DIR);
      xpos    <= COORD_W'(START_X);
      ypos    <= COORD_W'(START_Y);
      dir     <= 2'(START_DIR);
      anim    <= '0;
      map_x   <= COORD_W'(START_X);
      map_y   <= COORD_W'(START_Y);
      moved   <= 1'b0;
      blocked <= 1'b0;
      busy    <= 1'b0;
    end else begin
      moved   <= 1'b0;
      blocked <= 1'b0;
      if (ce) cnt <= (cnt == DIV_W'(STEP_DIV - 1)) ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          busy <= tick;
          if (tick) begin
            pend  <= req_dir;
            // An out-of-bounds target is never looked up; the address stays on the current tile.
            map_x <= nb_req[2*COORD_W] ? nb_req[COORD_W-1:0] : xpos;
            map_y <= nb_req[2*COORD_W] ? nb_req[2*COORD_W-1:COORD_W] : ypos;
            state <= Q_REQ;
          end
        end
        Q_REQ, C_REQ: begin
          lat_cnt <= LAT_W'(MAP_LAT - 1);
          if (MAP_LAT > 1) state <= (state == Q_REQ) ? Q_WAIT : C_WAIT;
          else             state <= (state == Q_REQ) ? Q_EVAL : C_EVAL;
        end
        Q_WAIT, C_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) state <= (state == Q_WAIT) ? Q_EVAL : C_EVAL;
        end
        Q_EVAL: begin
          if (nb_pend[2*COORD_W] && !map_wall) begin
            xpos  <= nb_pend[COORD_W-1:0];
            ypos  <= nb_pend[2*COORD_W-1:COORD_W];
            map_x <= nb_pend[COORD_W-1:0];
            map_y <= nb_pend[2*COORD_W-1:COORD_W];
            dir   <= pend;
            anim  <= anim_next(anim);
            moved <= 1'b1;
            state <= IDLE;
          end else if (pend == dir) begin
            blocked <= 1'b1;
            map_x   <= xpos;
            map_y   <= ypos;
            state   <= IDLE;
          end else begin
            map_x <= nb_dir[2*COORD_W] ? nb_dir[COORD_W-1:0] : xpos;
            map_y <= nb_dir[2*COORD_W] ? nb_dir[2*COORD_W-1:COORD_W] : ypos;
            state <= C_REQ;
          end
        end
        C_EVAL: begin
          if (nb_dir[2*COORD_W] && !map_wall) begin
            xpos  <= nb_dir[COORD_W-1:0];
            ypos  <= nb_dir[2*COORD_W-1:COORD_W];
            map_x <= nb_dir[COORD_W-1:0];
            map_y <= nb_dir[2*COORD_W-1:COORD_W];
            anim  <= anim_next(anim);
            moved <= 1'b1;
          end else begin
            blocked <= 1'b1;
            map_x   <= xpos;
            map_y   <= ypos;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_actor_ctrl.sv
// Directed bench for grid_actor_ctrl: a MAP_LAT=1 and a MAP_LAT=3 instance against a tile-map model
// whose wall flag is only truthful exactly MAP_LAT cycles after each address change.
module tb_grid_actor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ce, ce3;
  logic [1:0] req_dir, req_dir3;

  logic [4:0] map_x, map_y, xpos, ypos;
  logic [1:0] dir;
  logic [0:0] anim;
  logic       map_wall, moved, blocked, busy;

  logic [4:0] map_x3, map_y3, xpos3, ypos3;
  logic [1:0] dir3;
  logic [0:0] anim3;
  logic       map_wall3, moved3, blocked3, busy3;

  grid_actor_ctrl dut (
    .clk(clk), .reset(reset), .ce(ce), .req_dir(req_dir),
    .map_x(map_x), .map_y(map_y), .map_wall(map_wall),
    .xpos(xpos), .ypos(ypos), .dir(dir), .anim(anim),
    .moved(moved), .blocked(blocked), .busy(busy)
  );

  grid_actor_ctrl #(.MAP_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .ce(ce3), .req_dir(req_dir3),
    .map_x(map_x3), .map_y(map_y3), .map_wall(map_wall3),
    .xpos(xpos3), .ypos(ypos3), .dir(dir3), .anim(anim3),
    .moved(moved3), .blocked(blocked3), .busy(busy3)
  );

  // Tile map: wall[y][x]. Off-latency cycles present the inverted flag.
  logic wall [0:31][0:31];
  int   age = 0, age3 = 0, cyc = 0;
  logic [9:0] prev = '0, prev3 = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    prev  <= {map_y, map_x};
    prev3 <= {map_y3, map_x3};
    if ({map_y, map_x} != prev) age <= 1;
    else if (age < 7) age <= age + 1;
    if ({map_y3, map_x3} != prev3) age3 <= 1;
    else if (age3 < 7) age3 <= age3 + 1;
  end

  assign map_wall  = (age == 1)  ? wall[map_y][map_x]   : ~wall[map_y][map_x];
  assign map_wall3 = (age3 == 3) ? wall[map_y3][map_x3] : ~wall[map_y3][map_x3];

  logic       sel = 1'b0;
  logic       cur_busy, cur_moved, cur_blocked;
  logic [4:0] cur_map_x;
  assign cur_busy    = sel ? busy3    : busy;
  assign cur_moved   = sel ? moved3   : moved;
  assign cur_blocked = sel ? blocked3 : blocked;
  assign cur_map_x   = sel ? map_x3   : map_x;

  int total = 0, bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ce = 1'b0; ce3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for the next step window of the selected instance and reports what it did.
  task automatic run_step(output logic mv, output logic bl, output int blen,
                          output logic map_bad, output int mv_cyc);
    int n;
    mv = 1'b0; bl = 1'b0; blen = 0; map_bad = 1'b0; mv_cyc = -1; n = 0;
    while (!cur_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check("tick_timeout", 0, 1);
      return;
    end
    while (cur_busy && blen < 40) begin
      if (cur_moved && !mv) begin mv = 1'b1; mv_cyc = cyc; end
      if (cur_blocked) bl = 1'b1;
      if (cur_map_x < 5'd1 || cur_map_x > 5'd28) map_bad = 1'b1;
      blen++;
      @(negedge clk);
    end
    if (blen >= 40) check("busy_timeout", 0, 1);
  endtask

  logic mv, bl, mb, seen;
  int   blen, c1, c2;

  initial begin
    reset = 1'b1; ce = 1'b0; ce3 = 1'b0; req_dir = 2'd3; req_dir3 = 2'd3;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) wall[y][x] = 1'b0;
    do_reset();

    check("rst_xpos", xpos, 2);   check("rst_ypos", ypos, 2);
    check("rst_dir", dir, 3);     check("rst_anim", anim, 0);
    check("rst_map_x", map_x, 2); check("rst_map_y", map_y, 2);
    check("rst_moved", moved, 0); check("rst_blocked", blocked, 0);
    check("rst_busy", busy, 0);   check("rst_xpos3", xpos3, 2);

    // ce held low: nothing may happen
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (busy || busy3 || moved || blocked) seen = 1'b1;
    end
    check("celow_activity", seen, 0);
    check("celow_xpos", xpos, 2);
    check("celow_map_x", map_x, 2);

    // open map, straight right
    sel = 1'b0; req_dir = 2'd3; ce = 1'b1;
    run_step(mv, bl, blen, mb, c1);
    check("t1a_moved", mv, 1);  check("t1a_blocked", bl, 0);
    check("t1a_xpos", xpos, 3); check("t1a_anim", anim, 1);
    check("t1a_busy_len", blen, 3);
    run_step(mv, bl, blen, mb, c2);
    check("t1b_xpos", xpos, 4); check("t1b_anim", anim, 0);
    check("t1b_period", c2 - c1, 15);

    // turn down blocked by wall, fall back to right; then wall cleared
    do_reset();
    wall[3][2] = 1'b1; req_dir = 2'd2; ce = 1'b1;
    run_step(mv, bl, blen, mb, c1);
    check("t2a_moved", mv, 1);  check("t2a_xpos", xpos, 3);
    check("t2a_ypos", ypos, 2); check("t2a_dir", dir, 3);
    check("t2a_busy_len", blen, 5);
    wall[3][2] = 1'b0;
    run_step(mv, bl, blen, mb, c1);
    check("t2b_dir", dir, 2);   check("t2b_ypos", ypos, 3);
    check("t2b_xpos", xpos, 3); check("t2b_busy_len", blen, 3);

    // left edge at (1,5) heading left
    do_reset();
    req_dir = 2'd2; ce = 1'b1;
    repeat (3) run_step(mv, bl, blen, mb, c1);
    check("t3_ypos", ypos, 5);
    req_dir = 2'd1;
    run_step(mv, bl, blen, mb, c1);
    check("t3_xpos1", xpos, 1); check("t3_dir1", dir, 1);
    run_step(mv, bl, blen, mb, c1);
`ifdef WRAP_TUNNEL_EN
    check("t3_wrap_moved", mv, 1);
    check("t3_wrap_xpos", xpos, 28);
`else
    check("t3_edge_blocked", bl, 1);
    check("t3_edge_moved", mv, 0);
    check("t3_edge_xpos", xpos, 1);
    check("t3_edge_busy_len", blen, 3);
`endif
    check("t3_map_x_range", mb, 0);
    check("t3_edge_ypos", ypos, 5);
    ce = 1'b0;

    // MAP_LAT=3 instance
    do_reset();
    sel = 1'b1; req_dir3 = 2'd3; ce3 = 1'b1;
    run_step(mv, bl, blen, mb, c1);
    check("t4a_moved", mv, 1); check("t4a_xpos", xpos3, 3);
    check("t4a_busy_len", blen, 5);
    wall[3][3] = 1'b1; req_dir3 = 2'd2;
    run_step(mv, bl, blen, mb, c1);
    check("t4b_moved", mv, 1);   check("t4b_xpos", xpos3, 4);
    check("t4b_ypos", ypos3, 2); check("t4b_dir", dir3, 3);
    check("t4b_busy_len", blen, 9);
    wall[3][3] = 1'b0;

    // reset during Q_WAIT
    req_dir3 = 2'd3;
    begin
      int n = 0;
      while (!busy3 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (n >= 60) check("t5_tick_timeout", 0, 1);
    end
    @(negedge clk);
    reset = 1'b1; ce3 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t5_xpos", xpos3, 2); check("t5_ypos", ypos3, 2);
    check("t5_dir", dir3, 3);   check("t5_busy", busy3, 0);
    check("t5_moved", moved3, 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (moved3 || busy3) seen = 1'b1;
    end
    check("t5_quiet", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_actor_ctrl.md
# grid_actor_ctrl

Parametrised grid-movement controller for maze actors (player and ghosts) on the tile map. It paces steps from the pixel-clock enable and checks the target tile with a registered map-RAM lookup. It buffers a requested turn and applies it as soon as it is legal, otherwise keeping the current heading. It outputs the tile position, heading and animation frame to the sprite renderer.

## Interface
- COORD_W, 5: tile coordinate width in bits.
- X_MIN, 1: lowest legal column, inclusive.
- X_MAX, 28: highest legal column, inclusive.
- Y_MIN, 1: lowest legal row, inclusive.
- Y_MAX, 28: highest legal row, inclusive.
- START_X, 2: reset column.
- START_Y, 2: reset row.
- START_DIR, 3: reset heading.
- STEP_DIV, 15: ce pulses per step attempt; must be at least 2*MAP_LAT+4.
- ANIM_FRAMES, 2: animation frame count; must be at least 1.
- MAP_LAT, 1: map read latency in cycles; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  step-pacing enable.
- req_dir  in  2  requested heading: 0 up (y-1), 1 left (x-1), 2 down (y+1), 3 right (x+1).
- map_x  out  COORD_W  map query column.
- map_y  out  COORD_W  map query row.
- map_wall  in  1  wall flag for (map_x, map_y), valid MAP_LAT cycles after the address.
- xpos  out  COORD_W  current column.
- ypos  out  COORD_W  current row.
- dir  out  2  current heading.
- anim  out  clog2(ANIM_FRAMES)  animation frame.
- moved  out  1  one-cycle pulse when the position changes.
- blocked  out  1  one-cycle pulse when a step attempt fails.
- busy  out  1  high while the step FSM is not IDLE.

## Operation
- Pacing counter counts ce pulses 0..STEP_DIV-1 and wraps. The terminal count with ce high is a step tick. The counter keeps running while busy. A tick that arrives while the FSM is not IDLE is dropped.
- req_dir is latched into a pending register in the step-tick cycle only.
- Neighbour calculation:
  - Uses COORD_W+1 bits so that x-1 at 0 underflows detectably.
  - A target is in-bounds only if it lies within [X_MIN..X_MAX] x [Y_MIN..Y_MAX].
- FSM states:
  - IDLE: map_x/map_y = current position.
  - Q_REQ/Q_WAIT: drive the neighbour in the pending heading and hold it for MAP_LAT cycles.
  - Q_EVAL: if in-bounds and !map_wall, then dir <= pending, position <= target, moved pulses, and the FSM returns to IDLE. Else go to C_REQ.
  - C_REQ/C_WAIT: drive the neighbour in the current dir. If pending == dir, skip straight to the blocked outcome without a second lookup.
  - C_EVAL: if clear, move (dir unchanged) and pulse moved. Else pulse blocked, position and dir unchanged. Return to IDLE.
  - An out-of-bounds target is treated as a wall without waiting for map_wall; the wait cycles are still spent.
- anim advances modulo ANIM_FRAMES on every successful move only. With ANIM_FRAMES=1, anim is held at 0.
- Reset values: xpos=START_X, ypos=START_Y, dir=START_DIR, anim=0, map_x=START_X, map_y=START_Y, moved=0, blocked=0, busy=0. Counter = 0, FSM = IDLE.
- Reset asserted mid-step aborts the step with no position update.
- Reset has priority over ce and over any evaluation in the same cycle.

## Timing
- Tick at edge E0 → Q_REQ. The address is valid after E0. map_wall is sampled at edge E0+MAP_LAT+1. A successful first-choice move updates xpos/ypos/dir at that edge, with moved high for the following cycle.
- The fallback path adds MAP_LAT+1 cycles. Worst-case busy duration is 2*MAP_LAT+3 cycles.
- map_x/map_y change only on FSM transitions and stay stable throughout each wait.
- moved and blocked are mutually exclusive and never high for two consecutive cycles.

## Configuration
- WRAP_TUNNEL_EN defined:
  - A horizontal target of X_MAX+1 wraps to X_MIN, and X_MIN-1 wraps to X_MAX.
  - The wrapped cell is still wall-checked.
  - Vertical moves are unaffected.
- WRAP_TUNNEL_EN undefined: a horizontal out-of-bounds target is blocked like any wall.

## Test plan
- Open map, reset, req_dir=3 held, STEP_DIV=15, ce every cycle → xpos 2→3→4, one moved pulse every 15 cycles, anim toggles 0/1.
- Pos (2,2), dir=3, req_dir=2 with a wall at (2,3) → first lookup (2,3) blocked, fallback (3,2) moves; dir stays 3. The wall is then cleared at the next tick → dir=2, ypos=3.
- Pos (1,5), dir=1, req_dir=1:
  - Macro undefined: blocked pulse, xpos stays 1, and map_x never shows an underflowed value while the FSM is evaluating.
  - WRAP_TUNNEL_EN defined: xpos becomes 28.
- MAP_LAT=3, map_wall driven valid only exactly 3 cycles after the address → correct decision, and busy lasts 5 cycles (first choice) or 9 cycles (fallback).
- reset asserted during Q_WAIT → next cycle xpos=2, ypos=2, dir=3, busy=0, no moved pulse.
- ce low throughout → no tick, busy=0, outputs unchanged indefinitely.
